// File: rtl/fib_param.sv
// Parametrised iterative Fibonacci engine: one addition per clock, start/ready/done_tick handshake,
// overflow saturation and synchronous abort. Optional term streaming is enabled with FIB_STREAM_EN.
module fib_param #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [IDX_W-1:0]  i,
    output logic              ready,
    output logic              busy,
    output logic              done_tick,
    output logic              ovf,
    output logic [DATA_W-1:0] f
`ifdef FIB_STREAM_EN
    ,
    output logic              term_valid,
    output logic [DATA_W-1:0] term
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [DATA_W-1:0]   t0_r, t0_s;
    logic [DATA_W-1:0]   t1_r, t1_s;
    logic [IDX_W-1:0]    n_r, n_s;
    logic                ovf_r, ovf_s;
    logic [DATA_W:0]     sum_s;

    // Carry-extended sum; the top bit flags that the next term does not fit.
    always_comb begin
        sum_s = {1'b0, t1_r} + {1'b0, t0_r};
    end

    // Next-state and datapath update; abort outranks every OP/DONE transition.
    always_comb begin
        state_s = state_r;
        t0_s    = t0_r;
        t1_s    = t1_r;
        n_s     = n_r;
        ovf_s   = ovf_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    t0_s    = {DATA_W{1'b0}};
                    t1_s    = DATA_W'(1);
                    n_s     = i;
                    ovf_s   = 1'b0;
                    state_s = OP;
                end else begin
                    state_s = IDLE;
                end
            end
            OP: begin
                if (abort) begin
                    ovf_s   = 1'b0;
                    state_s = IDLE;
                end else if (n_r == {IDX_W{1'b0}}) begin
                    t1_s    = {DATA_W{1'b0}};
                    state_s = DONE;
                end else if (n_r == IDX_W'(1)) begin
                    state_s = DONE;
                end else if (sum_s[DATA_W]) begin
                    t1_s    = {DATA_W{1'b1}};
                    ovf_s   = 1'b1;
                    state_s = DONE;
                end else begin
                    t1_s    = sum_s[DATA_W-1:0];
                    t0_s    = t1_r;
                    n_s     = n_r - IDX_W'(1);
                    state_s = OP;
                end
            end
            DONE: begin
                if (abort) begin
                    ovf_s   = 1'b0;
                    state_s = IDLE;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            t0_r    <= {DATA_W{1'b0}};
            t1_r    <= {DATA_W{1'b0}};
            n_r     <= {IDX_W{1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            t0_r    <= t0_s;
            t1_r    <= t1_s;
            n_r     <= n_s;
            ovf_r   <= ovf_s;
        end
    end

    // Handshake flags decode straight from the state register.
    always_comb begin
        ready     = (state_r == IDLE);
        busy      = (state_r == OP);
        done_tick = (state_r == DONE);
        ovf       = ovf_r;
        f         = t1_r;
    end

`ifdef FIB_STREAM_EN
    logic              add_s;
    logic              term_valid_r;
    logic [DATA_W-1:0] term_r;

    // A term is emitted only for an OP cycle that really performs a fitting addition.
    always_comb begin
        add_s = (state_r == OP) && !abort && (n_r > IDX_W'(1)) && !sum_s[DATA_W];
    end

    // Stream register, aligned with the t1 update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            term_valid_r <= 1'b0;
            term_r       <= {DATA_W{1'b0}};
        end else begin
            term_valid_r <= add_s;
            if (add_s) begin
                term_r <= sum_s[DATA_W-1:0];
            end else begin
                term_r <= term_r;
            end
        end
    end

    // Stream outputs.
    always_comb begin
        term_valid = term_valid_r;
        term       = term_r;
    end
`endif

endmodule

// File: tb/tb_fib_param.sv
// Directed bench for fib_param: a 32-bit instance for the main cases and a 16-bit instance for overflow.
module tb_fib_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, abort_a, start_b, abort_b;
    logic [5:0]  i_a, i_b;
    logic        ready_a, busy_a, done_a, ovf_a;
    logic        ready_b, busy_b, done_b, ovf_b;
    logic [31:0] f_a;
    logic [15:0] f_b;
`ifdef FIB_STREAM_EN
    logic        tv_a, tv_b;
    logic [31:0] term_a;
    logic [15:0] term_b;
    logic [31:0] terms[$];
`endif

    int vectors    = 0;
    int miscompares = 0;
    int sel        = 0;

    logic        cur_done, cur_ready, cur_busy, cur_ovf;
    logic [31:0] cur_f;

    fib_param #(.DATA_W(32), .IDX_W(6)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .i(i_a),
        .ready(ready_a), .busy(busy_a), .done_tick(done_a), .ovf(ovf_a), .f(f_a)
`ifdef FIB_STREAM_EN
        , .term_valid(tv_a), .term(term_a)
`endif
    );

    fib_param #(.DATA_W(16), .IDX_W(6)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .i(i_b),
        .ready(ready_b), .busy(busy_b), .done_tick(done_b), .ovf(ovf_b), .f(f_b)
`ifdef FIB_STREAM_EN
        , .term_valid(tv_b), .term(term_b)
`endif
    );

    always_comb begin
        if (sel == 1) begin
            cur_done = done_b; cur_ready = ready_b; cur_busy = busy_b;
            cur_ovf = ovf_b; cur_f = {16'h0000, f_b};
        end else begin
            cur_done = done_a; cur_ready = ready_a; cur_busy = busy_a;
            cur_ovf = ovf_a; cur_f = f_a;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pulses start for one edge; returns at the negedge of OP cycle 1.
    task automatic kick(input int s, input logic [5:0] idx);
        sel = s;
        if (s == 1) begin i_b = idx; start_b = 1'b1; end
        else begin i_a = idx; start_a = 1'b1; end
        step();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Counts cycles (starting at 'first') until done_tick; lat = -1 if the budget expires.
    task automatic wait_done(input int first, output int lat, output int rdy);
        lat = first;
        rdy = 0;
        while (!cur_done && lat < 200) begin
            if (cur_ready) rdy++;
`ifdef FIB_STREAM_EN
            if (sel == 0 && tv_a) terms.push_back(term_a);
`endif
            step();
            lat++;
        end
        if (!cur_done) lat = -1;
    endtask

    initial begin
        int lat, rdy;
        int dones[$];
        rst = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; i_a = 6'd0;
        start_b = 1'b0; abort_b = 1'b0; i_b = 6'd0;
        #1;
        check("rst_ready", ready_a, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_f", f_a, 32'd0);
        check("rst_ovf", ovf_a, 1'b0);
        check("rst_f16", f_b, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        kick(0, 6'd0);
        wait_done(1, lat, rdy);
        check("i0_lat", lat, 2);
        check("i0_f", cur_f, 32'd0);
        check("i0_ovf", cur_ovf, 1'b0);
        step();

        kick(0, 6'd1);
        wait_done(1, lat, rdy);
        check("i1_lat", lat, 2);
        check("i1_f", cur_f, 32'd1);
        step();

        kick(0, 6'd10);
        check("i10_busy", cur_busy, 1'b1);
        wait_done(1, lat, rdy);
        check("i10_lat", lat, 11);
        check("i10_f", cur_f, 32'd55);
        check("i10_ready_low", rdy, 0);
        check("i10_done_ready", cur_ready, 1'b0);
        step();
        check("i10_back_idle", cur_ready, 1'b1);
        check("i10_done_clear", cur_done, 1'b0);

        kick(0, 6'd30);
        wait_done(1, lat, rdy);
        check("i30_lat", lat, 31);
        check("i30_f", cur_f, 32'd832040);
        check("i30_ready_low", rdy, 0);
        step();

        kick(1, 6'd24);
        wait_done(1, lat, rdy);
        check("w16_i24_lat", lat, 25);
        check("w16_i24_f", cur_f, 32'd46368);
        check("w16_i24_ovf", cur_ovf, 1'b0);
        step();

        kick(1, 6'd25);
        wait_done(1, lat, rdy);
        check("w16_i25_lat", lat, 25);
        check("w16_i25_f", cur_f, 32'h0000FFFF);
        check("w16_i25_ovf", cur_ovf, 1'b1);
        step(); step(); step();
        check("w16_hold_f", cur_f, 32'h0000FFFF);
        check("w16_hold_ovf", cur_ovf, 1'b1);
        kick(1, 6'd2);
        check("w16_ovf_cleared", cur_ovf, 1'b0);
        wait_done(1, lat, rdy);
        check("w16_i2_lat", lat, 3);
        check("w16_i2_f", cur_f, 32'd1);
        step();

        // Abort in IDLE must be ignored.
        sel = 0;
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        check("idle_abort_ready", cur_ready, 1'b1);
        check("idle_abort_f", cur_f, 32'd832040);

        kick(0, 6'd20);
        rdy = 0;
        for (int c = 1; c < 5; c++) begin
            if (cur_done) rdy++;
            step();
        end
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        check("abort_no_done", rdy + cur_done, 0);
        check("abort_ready", cur_ready, 1'b1);
        check("abort_busy", cur_busy, 1'b0);
        check("abort_ovf", cur_ovf, 1'b0);
        kick(0, 6'd20);
        wait_done(1, lat, rdy);
        check("i20_lat", lat, 21);
        check("i20_f", cur_f, 32'd6765);
        step();

        // start held high: done every 5 cycles.
        sel = 0;
        i_a = 6'd3;
        start_a = 1'b1;
        step();
        for (int c = 1; c <= 15; c++) begin
            if (cur_done) begin
                dones.push_back(c);
                check("held_f", cur_f, 32'd2);
            end
            step();
        end
        start_a = 1'b0;
        check("held_count", dones.size(), 3);
        for (int k = 0; k < 3; k++)
            check("held_cycle", (k < dones.size()) ? dones[k] : -1, 4 + 5 * k);
        wait_done(1, lat, rdy);
        check("held_last_f", cur_f, 32'd2);
        step();

        kick(0, 6'd5);
        step();
        start_a = 1'b1;
        i_a = 6'd9;
        step();
        start_a = 1'b0;
        wait_done(3, lat, rdy);
        check("op_start_lat", lat, 6);
        check("op_start_f", cur_f, 32'd5);
        step();

`ifdef FIB_STREAM_EN
        terms.delete();
        kick(0, 6'd1);
        wait_done(1, lat, rdy);
        check("stream_n1_none", terms.size(), 0);
        step();
        terms.delete();
        kick(0, 6'd6);
        wait_done(1, lat, rdy);
        begin
            logic [31:0] exp_t[5] = '{32'd1, 32'd2, 32'd3, 32'd5, 32'd8};
            check("stream_count", terms.size(), 5);
            for (int k = 0; k < 5; k++)
                check("stream_term", (k < terms.size()) ? terms[k] : 32'hDEADBEEF, exp_t[k]);
        end
        check("stream_f", cur_f, 32'd8);
        step();
`endif

        // Asynchronous reset mid-run.
        kick(0, 6'd40);
        for (int c = 0; c < 10; c++) step();
        check("mid_busy", cur_busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_ready", ready_a, 1'b1);
        check("mid_rst_busy", busy_a, 1'b0);
        check("mid_rst_done", done_a, 1'b0);
        check("mid_rst_f", f_a, 32'd0);
        check("mid_rst_ovf", ovf_a, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_ready", ready_a, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
